if_prefetch_queue: RTL

- Instruction prefetch queue between the asynchronous instruction ROM (im) and the CPU fetch port (SCPU inst_in / PC_out path).
- Owns the fetch PC and drives the ROM address.
- Reads one word per cycle into a small FIFO of {pc, instr} pairs and presents the head to the CPU with a valid/ready handshake.
- Flushes and restarts on a branch/jump redirect from the CPU.

---
 rtl/if_pkg.sv | 24 ++
 rtl/pq_fifo.sv | 79 +++++++
 rtl/if_prefetch_queue.sv | 102 ++++++++++
 3 files changed

// File: rtl/if_pkg.sv
// Shared definitions for the instruction prefetch queue.
//   XLEN             : PC / instruction width
//   NOP_INSTR        : instruction presented when the queue is empty (addi x0,x0,0)
//   RESET_PC_DEFAULT : default fetch PC after reset
//   fetch_entry_t    : one queue slot, {pc, instr}
//   align_word()     : clears the byte-offset bits of an address
package if_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

    // Word-align an address; a mask is used so every bit of the input is consumed.
    function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
        return addr & {{(XLEN-2){1'b1}}, 2'b00};
    endfunction

endpackage

// File: rtl/pq_fifo.sv
// Generic synchronous FIFO of fetch_entry_t used as the prefetch store.
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   push, pop    : enqueue push_data / dequeue head (ignored when full / empty,
//                  except that push is accepted when full if pop happens too)
//   flush        : discard every entry (reset wins over flush, flush over push/pop)
//   push_data    : entry written at the tail
//   head         : entry at the head (storage output, no bypass from push_data)
//   count        : occupancy, 0..DEPTH
//   full, empty  : count == DEPTH / count == 0
module pq_fifo
    import if_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  fetch_entry_t     push_data,
    output fetch_entry_t     head,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    fetch_entry_t     mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    // Qualify requests against occupancy; a push into a full FIFO is legal when a pop frees a slot.
    always_comb begin
        pop_ok_s  = 1'b0;
        push_ok_s = 1'b0;
        pop_ok_s  = pop & ~empty;
        push_ok_s = push & (~full | pop_ok_s);
    end

    // Pointer, occupancy and storage update; pointers wrap modulo DEPTH.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {$bits(fetch_entry_t){1'b0}};
            end
        end else if (flush) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push_ok_s) begin
                mem_r[wr_ptr_r] <= push_data;
                wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign head  = mem_r[rd_ptr_r];
    assign count = count_r;
    assign full  = (count_r == CNT_W'(DEPTH));
    assign empty = (count_r == {CNT_W{1'b0}});

endmodule

// File: rtl/if_prefetch_queue.sv
// Instruction prefetch queue between an asynchronous instruction ROM and the
// CPU fetch port. Owns the fetch PC, reads one ROM word per cycle into a FIFO
// of {pc, instr} pairs and presents the head with a valid/ready handshake.
// A redirect flushes the queue and restarts fetch at the (word-aligned) target.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   im_addr / im_dout   : ROM word address (from fetch PC) / ROM data (same cycle)
//   inst_valid          : head holds a valid instruction
//   inst_ready          : CPU takes the head this cycle
//   inst_out / inst_pc  : head instruction / its PC (NOP / 0 when empty)
//   redirect            : flush and restart fetch at redirect_pc
//   q_count             : current occupancy
module if_prefetch_queue #(
    parameter int                        DEPTH     = 4,
    parameter int                        XLEN      = if_pkg::XLEN,
    parameter int                        IM_ADDR_W = 7,
    parameter logic [if_pkg::XLEN-1:0]   RESET_PC  = if_pkg::RESET_PC_DEFAULT
) (
    input  logic                         clk,
    input  logic                         reset,
    output logic [IM_ADDR_W-1:0]         im_addr,
    input  logic [XLEN-1:0]              im_dout,
    output logic                         inst_valid,
    input  logic                         inst_ready,
    output logic [XLEN-1:0]              inst_out,
    output logic [XLEN-1:0]              inst_pc,
    input  logic                         redirect,
    input  logic [XLEN-1:0]              redirect_pc,
    output logic [$clog2(DEPTH+1)-1:0]   q_count
);

    import if_pkg::*;

    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [XLEN-1:0]  fetch_pc_r;
    logic             push_s;
    logic             pop_s;
    logic             full_s;
    logic             empty_s;
    logic [CNT_W-1:0] count_s;
    fetch_entry_t     head_s;
    fetch_entry_t     wr_entry_s;

    // Handshake: the CPU only consumes when the head is valid; a redirect blocks
    // new fetches, and the FIFO flush makes any pop in that cycle irrelevant.
    always_comb begin
        pop_s            = 1'b0;
        push_s           = 1'b0;
        wr_entry_s       = {$bits(fetch_entry_t){1'b0}};
        pop_s            = ~empty_s & inst_ready;
        push_s           = ~redirect & (~full_s | pop_s);
        wr_entry_s.pc    = fetch_pc_r;
        wr_entry_s.instr = im_dout;
    end

    // Fetch PC: reset, then redirect, then advance by one word whenever a fetch is stored.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_r <= RESET_PC;
        end else if (redirect) begin
            fetch_pc_r <= align_word(redirect_pc);
        end else if (push_s) begin
            fetch_pc_r <= fetch_pc_r + XLEN'(4);
        end else begin
            fetch_pc_r <= fetch_pc_r;
        end
    end

    pq_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push_s),
        .pop       (pop_s & ~redirect),
        .flush     (redirect),
        .push_data (wr_entry_s),
        .head      (head_s),
        .count     (count_s),
        .full      (full_s),
        .empty     (empty_s)
    );

    // Head presentation straight from FIFO storage, with safe values when empty.
    always_comb begin
        inst_out = NOP_INSTR;
        inst_pc  = {XLEN{1'b0}};
        if (empty_s) begin
            inst_out = NOP_INSTR;
            inst_pc  = {XLEN{1'b0}};
        end else begin
            inst_out = head_s.instr;
            inst_pc  = head_s.pc;
        end
    end

    assign inst_valid = ~empty_s;
    assign q_count    = count_s;
    assign im_addr    = fetch_pc_r[IM_ADDR_W+1:2];

endmodule
